// File: rtl/myproject_mul_pkg.sv
// Shared constants and helpers for the pipelined fixed-point multiplier.
package myproject_mul_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;
  localparam int SAT_WRAP      = 0;
  localparam int SAT_CLAMP     = 1;

  // Exact product width of the two 1-bit-extended operands.
  function automatic int unsigned prod_width(int unsigned w0, int unsigned w1);
    return w0 + w1 + 1;
  endfunction

  function automatic logic signed [63:0] sat_max_s(int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min_s(int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic signed [63:0] sat_max_u(int unsigned w);
    return (64'sd1 <<< w) - 64'sd1;
  endfunction

endpackage

// File: rtl/myproject_mul_pipe_if.sv
// Operand/result bundle of the pipelined multiplier; ce travels with the data.
interface myproject_mul_pipe_if #(
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 26
);
  logic                  ce;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  din_vld;
  logic [dout_WIDTH-1:0] dout;
  logic                  dout_vld;

  modport master (output ce, din0, din1, din_vld, input dout, dout_vld);
  modport slave  (input ce, din0, din1, din_vld, output dout, dout_vld);
endinterface

// File: rtl/myproject_mul_post.sv
// Combinational round / arithmetic shift / saturate-or-wrap from the raw product to dout.
module myproject_mul_post
  import myproject_mul_pkg::*;
#(
  parameter int P_WIDTH    = 27,
  parameter int dout_WIDTH = 26,
  parameter int SHIFT      = 0,
  parameter int ROUND      = ROUND_TRUNC,
  parameter int SAT        = SAT_WRAP,
  parameter int OUT_SIGNED = 0
) (
  input  logic signed [P_WIDTH-1:0] prod,
  output logic [dout_WIDTH-1:0]     res_c
);
  localparam int unsigned RW  = P_WIDTH + 1;
  localparam int unsigned SW  = RW - SHIFT;
  localparam int unsigned DW  = dout_WIDTH;
  localparam int unsigned RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [RW-1:0] RND =
    (ROUND == ROUND_HALF_UP && SHIFT > 0) ? (RW'(1) << RSH) : '0;
  localparam logic signed [63:0] HI = (OUT_SIGNED != 0) ? sat_max_s(DW) : sat_max_u(DW);
  localparam logic signed [63:0] LO = (OUT_SIGNED != 0) ? sat_min_s(DW) : 64'sd0;
  // Clamping only matters when the shifted value can exceed dout.
  localparam bit CLAMP = (SAT == SAT_CLAMP) && (DW < SW);

  logic signed [RW-1:0] sum;
  logic signed [RW-1:0] sh;
  logic signed [63:0]   val;

  always_comb begin
    sum   = RW'(prod) + RND;
    sh    = sum >>> SHIFT;
    val   = 64'(sh);
    res_c = dout_WIDTH'(val);
    if (CLAMP && (val > HI)) begin
      res_c = dout_WIDTH'(HI);
    end else if (CLAMP && (val < LO)) begin
      res_c = dout_WIDTH'(LO);
    end
  end
endmodule

// File: rtl/myproject_mul_pipe.sv
// Pipelined multiplier with per-operand signedness, rescaling and a tracked valid bit.
module myproject_mul_pipe
  import myproject_mul_pkg::*;
#(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 2,
  parameter int din0_WIDTH  = 14,
  parameter int din1_WIDTH  = 12,
  parameter int dout_WIDTH  = 26,
  parameter int din0_SIGNED = 0,
  parameter int din1_SIGNED = 0,
  parameter int SHIFT       = 0,
  parameter int ROUND       = ROUND_TRUNC,
  parameter int SAT         = SAT_WRAP
) (
  input logic                clk,
  input logic                reset,
  myproject_mul_pipe_if.slave bus
);
  localparam int unsigned W0 = din0_WIDTH;
  localparam int unsigned W1 = din1_WIDTH;
  localparam int unsigned DW = dout_WIDTH;
  localparam int unsigned P  = prod_width(W0, W1);
  localparam int unsigned NS = NUM_STAGE;
  localparam int OUT_SIGNED  = (din0_SIGNED != 0 || din1_SIGNED != 0) ? 1 : 0;

  // Reject configurations the pipeline cannot build.
  if (NUM_STAGE < 1 || NUM_STAGE > 4 || ID < 0) begin : g_bad_param
    $error("myproject_mul_pipe: NUM_STAGE must be 1..4");
  end

  logic signed [W0:0]   a_e;
  logic signed [W1:0]   b_e;
  logic signed [P-1:0]  post_in;
  logic [DW-1:0]        post_c;
  logic [DW-1:0]        dout_q;
  logic [NS-1:0]        vld_q;

  assign a_e = {(din0_SIGNED != 0) && bus.din0[W0-1], bus.din0};
  assign b_e = {(din1_SIGNED != 0) && bus.din1[W1-1], bus.din1};

  if (NS == 1) begin : g_s1
    assign post_in = P'(a_e) * P'(b_e);
  end else begin : g_sn
    logic signed [W0:0]  a_q;
    logic signed [W1:0]  b_q;
    logic signed [P-1:0] prod_c;

    assign prod_c = P'(a_q) * P'(b_q);

    always_ff @(posedge clk) begin
      if (reset) begin
        a_q <= '0;
        b_q <= '0;
      end else if (bus.ce) begin
        a_q <= a_e;
        b_q <= b_e;
      end
    end

    if (NS == 2) begin : g_s2
      assign post_in = prod_c;
    end else begin : g_s3
      logic signed [P-1:0] pr_q [NS-2];

      // Raw-product delay line for the middle stages.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < NS - 2; i++) pr_q[i] <= '0;
        end else if (bus.ce) begin
          pr_q[0] <= prod_c;
          for (int i = 1; i < NS - 2; i++) pr_q[i] <= pr_q[i-1];
        end
      end

      assign post_in = pr_q[NS-3];
    end
  end

  myproject_mul_post #(
    .P_WIDTH   (P),
    .dout_WIDTH(dout_WIDTH),
    .SHIFT     (SHIFT),
    .ROUND     (ROUND),
    .SAT       (SAT),
    .OUT_SIGNED(OUT_SIGNED)
  ) u_post (
    .prod (post_in),
    .res_c(post_c)
  );

  // Final stage plus the valid shift register; ce freezes both.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
      vld_q  <= '0;
    end else if (bus.ce) begin
      dout_q <= post_c;
      vld_q  <= NS'({vld_q, bus.din_vld});
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = vld_q[NS-1];
endmodule

// File: tb/tb_myproject_mul_pipe.sv
// Directed bench for myproject_mul_pipe: latency, rounding, saturation, stalls, reset and a config sweep.
module tb_myproject_mul_pipe;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Unsigned 8x8->16, two stages
  myproject_mul_pipe_if #(.din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(16)) a_if ();
  myproject_mul_pipe #(.ID(1), .NUM_STAGE(2), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(16))
    u_a (.clk(clk), .reset(reset), .bus(a_if.slave));

  // Unsigned 8x8->16, three stages
  myproject_mul_pipe_if #(.din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(16)) c_if ();
  myproject_mul_pipe #(.ID(2), .NUM_STAGE(3), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(16))
    u_c (.clk(clk), .reset(reset), .bus(c_if.slave));

  // Signed 8x8->16, SHIFT=2, round vs truncate
  logic [7:0] r_a, r_b;
  logic       r_v;
  myproject_mul_pipe_if #(.din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(16)) r1_if ();
  myproject_mul_pipe_if #(.din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(16)) r0_if ();
  assign r1_if.ce = 1'b1; assign r1_if.din0 = r_a; assign r1_if.din1 = r_b; assign r1_if.din_vld = r_v;
  assign r0_if.ce = 1'b1; assign r0_if.din0 = r_a; assign r0_if.din1 = r_b; assign r0_if.din_vld = r_v;
  myproject_mul_pipe #(.ID(3), .NUM_STAGE(2), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(16),
    .din0_SIGNED(1), .din1_SIGNED(1), .SHIFT(2), .ROUND(1), .SAT(0))
    u_r1 (.clk(clk), .reset(reset), .bus(r1_if.slave));
  myproject_mul_pipe #(.ID(4), .NUM_STAGE(2), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(16),
    .din0_SIGNED(1), .din1_SIGNED(1), .SHIFT(2), .ROUND(0), .SAT(0))
    u_r0 (.clk(clk), .reset(reset), .bus(r0_if.slave));

  // Signed x unsigned -> 8, SHIFT=4, ROUND=1, clamp vs wrap
  logic [7:0] m_a, m_b;
  logic       m_v;
  myproject_mul_pipe_if #(.din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8)) m1_if ();
  myproject_mul_pipe_if #(.din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8)) m0_if ();
  assign m1_if.ce = 1'b1; assign m1_if.din0 = m_a; assign m1_if.din1 = m_b; assign m1_if.din_vld = m_v;
  assign m0_if.ce = 1'b1; assign m0_if.din0 = m_a; assign m0_if.din1 = m_b; assign m0_if.din_vld = m_v;
  myproject_mul_pipe #(.ID(5), .NUM_STAGE(2), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8),
    .din0_SIGNED(1), .din1_SIGNED(0), .SHIFT(4), .ROUND(1), .SAT(1))
    u_m1 (.clk(clk), .reset(reset), .bus(m1_if.slave));
  myproject_mul_pipe #(.ID(6), .NUM_STAGE(2), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8),
    .din0_SIGNED(1), .din1_SIGNED(0), .SHIFT(4), .ROUND(1), .SAT(0))
    u_m0 (.clk(clk), .reset(reset), .bus(m0_if.slave));

  // Sweep: 6x5->8, SHIFT=3, ROUND=1, SAT=1; g/4 selects latency, g%4 selects signedness
  logic [5:0] sw_a;
  logic [4:0] sw_b;
  logic       sw_v;
  logic [7:0] sw_dout [16];
  logic       sw_ov   [16];
  for (genvar g = 0; g < 16; g++) begin : g_sw
    myproject_mul_pipe_if #(.din0_WIDTH(6), .din1_WIDTH(5), .dout_WIDTH(8)) sif ();
    assign sif.ce = 1'b1; assign sif.din0 = sw_a; assign sif.din1 = sw_b; assign sif.din_vld = sw_v;
    myproject_mul_pipe #(.ID(100 + g), .NUM_STAGE(1 + g / 4), .din0_WIDTH(6), .din1_WIDTH(5),
      .dout_WIDTH(8), .din0_SIGNED(g % 2), .din1_SIGNED((g / 2) % 2), .SHIFT(3), .ROUND(1), .SAT(1))
      u_sw (.clk(clk), .reset(reset), .bus(sif.slave));
    assign sw_dout[g] = sif.dout;
    assign sw_ov[g]   = sif.dout_vld;
  end

  // Beats accepted downstream from u_c: dout_vld while ce is high
  int         c_cnt = 0;
  logic [15:0] c_q [$];
  always @(negedge clk) begin
    if (c_if.ce && c_if.dout_vld) begin
      c_cnt++;
      c_q.push_back(c_if.dout);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Integer reference for the sweep configuration
  function automatic logic [7:0] sw_ref(logic [5:0] a, logic [4:0] b, bit s0, bit s1);
    longint va, vb, p, lo, hi;
    va = s0 ? longint'($signed(a)) : longint'(a);
    vb = s1 ? longint'($signed(b)) : longint'(b);
    p  = (va * vb + 4) >>> 3;
    lo = (s0 || s1) ? -128 : 0;
    hi = (s0 || s1) ? 127 : 255;
    if (p > hi) p = hi;
    if (p < lo) p = lo;
    return 8'(p);
  endfunction

  int          base;
  int          qb;
  logic [15:0] stall_exp [4];
  logic [5:0]  tab_a [6];
  logic [4:0]  tab_b [6];

  initial begin
    stall_exp = '{16'd2, 16'd12, 16'd200, 16'd510};
    tab_a = '{6'd0, 6'd63, 6'd32, 6'd63, 6'd32, 6'd1};
    tab_b = '{5'd0, 5'd31, 5'd16, 5'd16, 5'd31, 5'd1};
    reset = 1'b1;
    a_if.ce = 1'b1; a_if.din0 = '0; a_if.din1 = '0; a_if.din_vld = 1'b0;
    c_if.ce = 1'b1; c_if.din0 = '0; c_if.din1 = '0; c_if.din_vld = 1'b0;
    r_a = '0; r_b = '0; r_v = 1'b0;
    m_a = '0; m_b = '0; m_v = 1'b0;
    sw_a = '0; sw_b = '0; sw_v = 1'b0;
    tick(); tick();
    chk("reset_a_dout", a_if.dout, 0);
    chk("reset_a_vld", a_if.dout_vld, 0);
    chk("reset_c_vld", c_if.dout_vld, 0);
    chk("reset_sw15_vld", sw_ov[15], 0);
    reset = 1'b0;

    // Basic latency
    a_if.din0 = 8'd3; a_if.din1 = 8'd5; a_if.din_vld = 1'b1;
    tick(); a_if.din_vld = 1'b0;
    chk("lat_early_vld", a_if.dout_vld, 0);
    tick();
    chk("lat_dout", a_if.dout, 15);
    chk("lat_vld", a_if.dout_vld, 1);
    a_if.din0 = 8'd255; a_if.din1 = 8'd255; a_if.din_vld = 1'b1;
    tick(); a_if.din_vld = 1'b0;
    tick();
    chk("lat_max_dout", a_if.dout, 16'hFE01);
    chk("lat_max_vld", a_if.dout_vld, 1);
    tick();
    chk("lat_single_pulse", a_if.dout_vld, 0);

    // Round vs truncate
    r_a = 8'd2; r_b = 8'd13; r_v = 1'b1;
    tick(); r_v = 1'b0; tick();
    chk("round_pos", r1_if.dout, 16'd7);
    chk("trunc_pos", r0_if.dout, 16'd6);
    chk("round_vld", r1_if.dout_vld, 1);
    r_a = 8'hFE; r_v = 1'b1;
    tick(); r_v = 1'b0; tick();
    chk("round_neg", r1_if.dout, 16'hFFFA);
    chk("trunc_neg", r0_if.dout, 16'hFFF9);

    // Mixed sign with clamp / wrap
    m_a = 8'h80; m_b = 8'hFF; m_v = 1'b1;
    tick(); m_v = 1'b0; tick();
    chk("sat_neg_clamp", m1_if.dout, 8'h80);
    chk("sat_neg_wrap", m0_if.dout, 8'h08);
    chk("sat_vld", m1_if.dout_vld, 1);
    m_a = 8'h7F; m_v = 1'b1;
    tick(); m_v = 1'b0; tick();
    chk("sat_pos_clamp", m1_if.dout, 8'h7F);
    chk("sat_pos_wrap", m0_if.dout, 8'hE8);

    // Reset with two beats in flight
    base = c_cnt;
    c_if.din0 = 8'd7; c_if.din1 = 8'd9; c_if.din_vld = 1'b1;
    tick();
    c_if.din0 = 8'd4; c_if.din1 = 8'd4;
    tick();
    reset = 1'b1; c_if.din_vld = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst_dout", c_if.dout, 0);
    chk("rst_vld", c_if.dout_vld, 0);
    repeat (3) begin
      tick();
      chk("rst_flush_vld", c_if.dout_vld, 0);
    end
    chk("rst_no_beats", c_cnt - base, 0);
    c_if.din0 = 8'd6; c_if.din1 = 8'd7; c_if.din_vld = 1'b1;
    tick(); c_if.din_vld = 1'b0;
    chk("rst_new_early1", c_if.dout_vld, 0);
    tick();
    chk("rst_new_early2", c_if.dout_vld, 0);
    tick();
    chk("rst_new_dout", c_if.dout, 42);
    chk("rst_new_vld", c_if.dout_vld, 1);
    tick();
    chk("rst_new_done", c_if.dout_vld, 0);

    // ce stall mid-stream
    base = c_cnt; qb = c_q.size();
    c_if.din0 = 8'd1; c_if.din1 = 8'd2; c_if.din_vld = 1'b1;
    tick();
    c_if.din0 = 8'd3; c_if.din1 = 8'd4;
    tick();
    c_if.din0 = 8'd10; c_if.din1 = 8'd20;
    tick();
    chk("stall_pre_dout", c_if.dout, 2);
    c_if.ce = 1'b0; c_if.din0 = 8'd255; c_if.din1 = 8'd2;
    repeat (5) begin
      tick();
      chk("stall_hold_dout", c_if.dout, 2);
      chk("stall_hold_vld", c_if.dout_vld, 1);
    end
    c_if.ce = 1'b1;
    tick(); c_if.din_vld = 1'b0;
    chk("stall_b1", c_if.dout, 12);
    tick();
    chk("stall_b2", c_if.dout, 200);
    tick();
    chk("stall_b3", c_if.dout, 510);
    tick();
    chk("stall_drain_vld", c_if.dout_vld, 0);
    chk("stall_count", c_cnt - base, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("stall_order%0d", i), c_q[qb + i], stall_exp[i]);

    // Sweep over latency and signedness
    for (int v = 0; v < 14; v++) begin
      if (v < 6) begin
        sw_a = tab_a[v]; sw_b = tab_b[v];
      end else begin
        sw_a = 6'($urandom_range(63, 0)); sw_b = 5'($urandom_range(31, 0));
      end
      sw_v = 1'b1;
      for (int j = 1; j <= 4; j++) begin
        tick();
        sw_v = 1'b0;
        for (int g = 0; g < 16; g++) begin
          if (1 + g / 4 == j) begin
            chk($sformatf("sweep_g%0d_v%0d_vld", g, v), sw_ov[g], 1);
            chk($sformatf("sweep_g%0d_v%0d_dout", g, v), sw_dout[g],
                sw_ref(sw_a, sw_b, bit'(g % 2), bit'((g / 2) % 2)));
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/myproject_mul_pipe.md
# myproject_mul_pipe

Parametrised, pipelined fixed-point multiplier for the generated dataflow layers. It multiplies two operands whose signedness is selected independently, then applies an optional right-shift with round/truncate and saturate/wrap. Results emerge after a fixed latency of NUM_STAGE clock-enabled cycles, with a valid bit tracked alongside. It replaces the combinational unsigned-only multiplier wherever a layer's product must be registered to close timing, or rescaled to the accumulator format.

## Interface
- ID, 1: instance tag; no functional effect.
- NUM_STAGE, 2: latency in ce-qualified cycles; legal values 1..4.
- din0_WIDTH, 14: width of din0.
- din1_WIDTH, 12: width of din1.
- dout_WIDTH, 26: width of dout.
- din0_SIGNED, 0: 1 means din0 is two's complement; 0 means unsigned.
- din1_SIGNED, 0: same, for din1.
- SHIFT, 0: arithmetic right shift applied to the full product; legal values 0..P-1.
- ROUND, 0: 0 truncates toward minus infinity; 1 rounds half-up (adds 2^(SHIFT-1) before the shift; no effect when SHIFT=0).
- SAT, 0: 0 keeps the low dout_WIDTH bits (wrap); 1 clamps to the dout range.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- ce  in  1  pipeline advance enable.
- din0  in  din0_WIDTH  operand 0.
- din1  in  din1_WIDTH  operand 1.
- din_vld  in  1  operands valid this cycle.
- dout  out  dout_WIDTH  scaled product.
- dout_vld  out  1  dout valid.

## Operation
- Operand extension: each operand is widened by 1 bit. Signed operands are sign-extended; unsigned operands are zero-extended. The product is a signed multiply of the extended operands.
- Product width: P = din0_WIDTH + din1_WIDTH + 1, exact with no loss.
- Output signedness: OUT_SIGNED = din0_SIGNED | din1_SIGNED.
- Post-processing sequence:
  1. Optional round add, computed in P+1 bits.
  2. Arithmetic right shift by SHIFT.
  3. Range handling:
     - SAT=1: clamp to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1] when OUT_SIGNED, else [0, 2^dout_WIDTH-1].
     - SAT=0: keep the low dout_WIDTH bits.
- If dout_WIDTH ≥ the shifted width, the result is sign-extended (OUT_SIGNED) or zero-extended, and SAT has no effect.
- Pipeline:
  - NUM_STAGE=1: a single register captures post(din0*din1).
  - NUM_STAGE≥2: stage 1 registers the extended operands. Stages 2..NUM_STAGE-1 register the raw product. The final stage registers the post-processed result.
- A valid shift register of depth NUM_STAGE carries din_vld.
- Data registers load regardless of din_vld. dout is defined only when dout_vld=1.
- No backpressure: the downstream stage must accept every dout_vld beat.

## Timing
- Reset: all data registers and all valid bits go to 0, so dout=0 and dout_vld=0 on the cycle after reset is sampled high.
- Reset overrides ce. Reset asserted mid-operation discards all in-flight beats; no dout_vld pulse follows for them.
- ce=1: every stage advances. Operands sampled at edge k appear on dout/dout_vld after edge k+NUM_STAGE-1.
- ce=0: every register, valid bits included, holds. dout and dout_vld stay stable for as long as ce is low.
- din_vld and operands are sampled only on edges where ce=1.
- Throughput is one beat per ce-high cycle.
- Back-to-back valid beats are never merged or dropped.
- dout has no combinational path from any input.

## Structure
- Shared package myproject_mul_pkg holds:
  - the function prod_width(w0,w1) returning P;
  - the ROUND_TRUNC/ROUND_HALF_UP constants;
  - the SAT_WRAP/SAT_CLAMP constants;
  - the clamp-bound functions for signed and unsigned output.
- One sub-module, myproject_mul_post: combinational round/shift/saturate from P bits to dout_WIDTH. It is instantiated once, ahead of the final stage register.

## Test plan
- Basic latency:
  - Setup: unsigned 8x8 -> 16, NUM_STAGE=2, SHIFT=0.
  - Stimulus: din0=3, din1=5, din_vld=1.
  - Required: dout=15 and dout_vld=1 exactly 2 edges later; all-ones inputs 255x255 give 65025.
- Round vs truncate:
  - Setup: signed 8x8 -> 16, SHIFT=2.
  - Stimulus 2x13: ROUND=1 gives 7; ROUND=0 gives 6.
  - Stimulus -2x13: ROUND=1 gives -6; ROUND=0 gives -7.
- Mixed sign with saturation:
  - Setup: din0 signed 8, din1 unsigned 8, dout 8, SHIFT=4, ROUND=1.
  - Stimulus: din0=0x80 (-128), din1=255.
  - Required: SAT=1 gives dout=0x80 (-128). SAT=0 gives the low 8 bits of -2040, i.e. 0x08.
- ce stall:
  - Stimulus: stream 4 valid beats with NUM_STAGE=3, dropping ce for 5 cycles mid-stream.
  - Required: outputs hold during the stall; all 4 results appear in order with correct values; the count of dout_vld cycles with ce=1 is 4.
- Reset mid-flight:
  - Stimulus: assert reset for 1 cycle while 2 beats are in the pipe.
  - Required: dout=0 and dout_vld=0 next cycle; the 2 beats never appear; a new beat after reset appears with normal latency.
- Sweep:
  - Setup: NUM_STAGE 1..4, all four signedness combinations.
  - Stimulus: random operands.
  - Required: dout matches the reference model bit-exactly.
